// File: rtl/pc_pkg.sv
// Shared defaults and next-PC select encoding for the fetch PC sequencer.
package pc_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0080;

  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_REDIR,
    SEL_HOLD,
    SEL_RAS,
    SEL_SEQ
  } next_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; entries are not reset, only the pointer and count.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   top_ptr_q, top_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wr_en;
  logic [PW-1:0]   wr_ptr;
  logic            pop_ok;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign top    = mem_q[top_ptr_q];
  assign pop_ok = pop && !empty;

  always_comb begin
    top_ptr_d = top_ptr_q;
    count_d   = count_q;
    wr_en     = 1'b0;
    wr_ptr    = top_ptr_q;
    if (flush) begin
      count_d = '0;
    end else if (push && pop_ok) begin
      // Pop then push lands in the same slot: replace the top in place.
      wr_en = 1'b1;
    end else if (push) begin
      top_ptr_d = top_ptr_q + PW'(1);
      wr_ptr    = top_ptr_q + PW'(1);
      wr_en     = 1'b1;
      if (!full) count_d = count_q + CW'(1);
    end else if (pop_ok) begin
      top_ptr_d = top_ptr_q - PW'(1);
      count_d   = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      top_ptr_q <= top_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC generator: exception/redirect/stall/return-prediction priority mux over a PC register.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(EXC_VEC_DEF),
  parameter int              INCR      = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            exc_valid,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INCR - 1);

  next_sel_e       sel;
  logic [XLEN-1:0] pc_q, pc_d, pc_inc, ras_top;
  logic            ras_underflow_q, ras_underflow_d;
  logic            misaligned_q, misaligned_d;
  logic            advancing, ras_push, ras_pop, ras_flush;

  assign pc_inc = pc_q + XLEN'(INCR);

  always_comb begin
    sel = SEL_SEQ;
    if (exc_valid)              sel = SEL_EXC;
    else if (redirect_valid)    sel = SEL_REDIR;
    else if (stall)             sel = SEL_HOLD;
    else if (ret && !ras_empty) sel = SEL_RAS;
  end

  // The RAS only moves on cycles where the PC follows the instruction stream.
  assign advancing = (sel == SEL_RAS) || (sel == SEL_SEQ);
  assign ras_push  = advancing && call;
  assign ras_pop   = advancing && ret;
  assign ras_flush = (sel == SEL_EXC);

  always_comb begin
    pc_d            = pc_inc;
    ras_underflow_d = 1'b0;
    misaligned_d    = 1'b0;
    unique case (sel)
      SEL_EXC:   pc_d = EXC_VEC;
      SEL_REDIR: begin
        pc_d         = redirect_target & ~ALIGN_MASK;
        misaligned_d = |(redirect_target & ALIGN_MASK);
      end
      SEL_HOLD:  pc_d = pc_q;
      SEL_RAS:   pc_d = ras_top;
      SEL_SEQ:   ras_underflow_d = ret && !call;
      default:   pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= RESET_VEC;
      ras_underflow_q <= 1'b0;
      misaligned_q    <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ras_underflow_q <= ras_underflow_d;
      misaligned_q    <= misaligned_d;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .XLEN  (XLEN)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ras_push),
    .pop   (ras_pop),
    .flush (ras_flush),
    .wdata (pc_inc),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  assign pc            = pc_q;
  assign ras_underflow = ras_underflow_q;
  assign misaligned    = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer: expected PCs queued at drive time, checked after each edge.
module tb_pc_sequencer;

  logic        clk, rst_n;
  logic        stall, redirect_valid, exc_valid, call, ret;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic        ras_empty, ras_full, ras_underflow, misaligned;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  int          checks = 0;
  int          errors = 0;

  pc_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_valid       (exc_valid),
    .call            (call),
    .ret             (ret),
    .pc              (pc),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .ras_underflow   (ras_underflow),
    .misaligned      (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired pc=%h", pc);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic s, input logic rv, input logic [31:0] t,
                       input logic e, input logic c, input logic r,
                       input logic [31:0] ep);
    stall = s; redirect_valid = rv; redirect_target = t;
    exc_valid = e; call = c; ret = r;
    exp_q.push_back(ep);
    @(posedge clk);
    #1;
    stall = 0; redirect_valid = 0; redirect_target = '0;
    exc_valid = 0; call = 0; ret = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h want=%h", pc, 32'h0); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", ras_empty); end
    checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", ras_full); end
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b want=0", ras_underflow); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned got=%b want=0", misaligned); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 32'h0, 0, 0, 0, 32'(4 * i));
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL idle_seq got=%h want=%h", pc, exp_pc); end
    end
  endtask

  task automatic test_stall_redirect;
    drive(0, 0, 32'h0, 0, 0, 0, 32'h10);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL pre_stall got=%h want=%h", pc, exp_pc); end
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 32'h0, 0, 0, 0, 32'h10);
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL stall_hold got=%h want=%h", pc, exp_pc); end
      checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL stall_misaligned got=%b want=0", misaligned); end
    end
    drive(1, 1, 32'h203, 0, 0, 0, 32'h200);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL stall_redirect got=%h want=%h", pc, exp_pc); end
    checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL misaligned_pulse got=%b want=1", misaligned); end
    drive(0, 0, 32'h0, 0, 0, 0, 32'h204);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL post_redirect got=%h want=%h", pc, exp_pc); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL misaligned_clear got=%b want=0", misaligned); end
  endtask

  task automatic test_call_ret;
    drive(0, 1, 32'h100, 0, 0, 0, 32'h100);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL cr_redirect got=%h want=%h", pc, exp_pc); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL cr_aligned got=%b want=0", misaligned); end
    drive(0, 0, 32'h0, 0, 1, 0, 32'h104);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL cr_call got=%h want=%h", pc, exp_pc); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL cr_nonempty got=%b want=0", ras_empty); end
    drive(0, 1, 32'h400, 0, 0, 0, 32'h400);
    drive(0, 0, 32'h0, 0, 0, 0, 32'h404);
    drive(0, 0, 32'h0, 0, 0, 0, 32'h408);
    for (int i = 0; i < 3; i++) begin
      exp_pc = exp_q.pop_front();
      checks++; if (pc === exp_pc && i < 2) begin errors++; $display("FAIL cr_stale got=%h want=%h", pc, 32'h408); end
    end
    checks++; if (pc !== 32'h408) begin errors++; $display("FAIL cr_idle got=%h want=%h", pc, 32'h408); end
    drive(0, 0, 32'h0, 0, 0, 1, 32'h104);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL cr_ret got=%h want=%h", pc, exp_pc); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL cr_empty got=%b want=1", ras_empty); end
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL cr_underflow got=%b want=0", ras_underflow); end
  endtask

  task automatic test_overflow;
    drive(0, 1, 32'h0, 0, 0, 0, 32'h0);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL of_redirect got=%h want=%h", pc, exp_pc); end
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 32'h0, 0, 1, 0, 32'(4 * i));
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL of_call got=%h want=%h", pc, exp_pc); end
    end
    checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL of_full got=%b want=1", ras_full); end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 32'h0, 0, 0, 1, 32'(32'h14 - 4 * k));
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL of_ret got=%h want=%h", pc, exp_pc); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL of_empty got=%b want=1", ras_empty); end
    checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL of_notfull got=%b want=0", ras_full); end
    drive(0, 0, 32'h0, 0, 0, 1, 32'hC);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL uf_pc got=%h want=%h", pc, exp_pc); end
    checks++; if (ras_underflow !== 1'b1) begin errors++; $display("FAIL uf_pulse got=%b want=1", ras_underflow); end
    drive(0, 0, 32'h0, 0, 0, 0, 32'h10);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL uf_next got=%h want=%h", pc, exp_pc); end
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got=%b want=0", ras_underflow); end
  endtask

  task automatic test_back_to_back;
    drive(0, 1, 32'h300, 0, 0, 0, 32'h300);
    drive(0, 0, 32'h0, 0, 1, 1, 32'h304);
    exp_pc = exp_q.pop_front();
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL cr_same_empty got=%h want=%h", pc, exp_pc); end
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL cr_same_uf got=%b want=0", ras_underflow); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL cr_same_count got=%b want=0", ras_empty); end
    drive(0, 0, 32'h0, 0, 1, 1, 32'h304);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL cr_same_pop got=%h want=%h", pc, exp_pc); end
    drive(0, 0, 32'h0, 0, 0, 1, 32'h308);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL cr_same_top got=%h want=%h", pc, exp_pc); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL cr_same_drain got=%b want=1", ras_empty); end
  endtask

  task automatic test_exception;
    drive(0, 1, 32'h500, 0, 0, 0, 32'h500);
    drive(0, 0, 32'h0, 0, 1, 0, 32'h504);
    drive(0, 0, 32'h0, 0, 1, 0, 32'h508);
    for (int i = 0; i < 3; i++) exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL exc_setup got=%h want=%h", pc, exp_pc); end
    drive(0, 0, 32'h0, 1, 0, 1, 32'h80);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL exc_pc got=%h want=%h", pc, exp_pc); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL exc_flush got=%b want=1", ras_empty); end
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL exc_uf got=%b want=0", ras_underflow); end
    drive(1, 0, 32'h0, 1, 1, 0, 32'h80);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL exc_over_stall got=%h want=%h", pc, exp_pc); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL exc_no_push got=%b want=1", ras_empty); end
  endtask

  task automatic test_wrap;
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL wrap_top got=%h want=%h", pc, exp_pc); end
    drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL wrap_zero got=%h want=%h", pc, exp_pc); end
  endtask

  task automatic test_async_reset;
    drive(0, 0, 32'h0, 0, 1, 0, 32'h4);
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL ar_pre got=%h want=%h", pc, exp_pc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL ar_pc got=%h want=%h", pc, 32'h0); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ar_empty got=%b want=1", ras_empty); end
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    stall = 0; redirect_valid = 0; redirect_target = '0;
    exc_valid = 0; call = 0; ret = 0; rst_n = 1'b0;
    test_reset();
    test_stall_redirect();
    test_call_ret();
    test_overflow();
    test_back_to_back();
    test_exception();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
